inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter NOP_INST, default 16'h0800, encoding driven on inst_o when no valid instruction is held.
REQ-002 Parameter MAX_WAIT, default 8, number of cycles mem_ready_i may stay low before timeout_o pulses.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 pc_i  input  16  fetch address from the PC stage.
REQ-006 pause_i  input  1  decode-stage stall; hold the IF/ID outputs.
REQ-007 flush_i  input  1  taken branch; discard the current or in-flight instruction.
REQ-008 mem_conflict_i  input  1  memory stage owns the shared bus this cycle.
REQ-009 mem_ready_i  input  1  instruction memory read completes; mem_data_i valid.
REQ-010 mem_data_i  input  16  instruction memory read data.
REQ-011 mem_req_o  output  1  instruction read request.
REQ-012 mem_addr_o  output  16  instruction read address.
REQ-013 inst_o  output  16  registered instruction to decode.
REQ-014 inst_pc_o  output  16  registered address of inst_o.
REQ-015 inst_valid_o  output  1  inst_o holds a real instruction.
REQ-016 fetch_pause_o  output  1  combinational stall to the PC stage, feeding its vmem_pause_i.
REQ-017 timeout_o  output  1  one-cycle pulse when a fetch has waited MAX_WAIT cycles.

Function
REQ-018 States: IDLE, REQ, HOLD, KILL, encoded in 2 bits.
REQ-019 IDLE: if mem_conflict_i=0 and pause_i=0 -> assert mem_req_o, mem_addr_o=pc_i, latch pc_i into req_pc, go to REQ; else stay in IDLE with mem_req_o=0.
REQ-020 REQ: mem_req_o=1, mem_addr_o=req_pc, both held stable until mem_ready_i=1.
REQ-021 REQ, mem_ready_i=1, flush_i=0, pause_i=0: inst_o<=mem_data_i, inst_pc_o<=req_pc, inst_valid_o<=1 next edge; return to IDLE.
REQ-022 REQ, mem_ready_i=1, pause_i=1, flush_i=0: capture data into the skid register and go to HOLD; IF/ID outputs unchanged.
REQ-023 HOLD: when pause_i falls, move the skid register into the IF/ID outputs and go to IDLE.
REQ-024 REQ, flush_i=1, mem_ready_i=0: go to KILL.
REQ-025 KILL: keep mem_req_o=1 until mem_ready_i=1, drop the returned data, then go to IDLE.
REQ-026 flush_i=1 in any state: next edge inst_o<=NOP_INST, inst_valid_o<=0, skid register invalidated; flush_i has priority over pause_i.
REQ-027 pause_i=1 with no completion: IF/ID outputs hold their values.
REQ-028 fetch_pause_o=1 when either:
- state is REQ/KILL and mem_ready_i=0;
- state is HOLD;
- state is IDLE and mem_conflict_i=1.
REQ-029 Minimum latency: pc_i at edge N -> inst_o valid after edge N+2 with zero-wait memory (ready in the REQ cycle).
REQ-030 Wait counter: cleared on entering REQ, counts while mem_ready_i=0, saturates at MAX_WAIT; timeout_o pulses once on reaching it; the FSM keeps waiting.
REQ-031 At most one request is outstanding; mem_addr_o wraps naturally at 16 bits (16'hFFFF then 16'h0000), with no special case.

Reset
REQ-032 rst=0 at posedge clk forces:
- state=IDLE; mem_req_o=0; mem_addr_o=0;
- inst_o=NOP_INST; inst_pc_o=0; inst_valid_o=0;
- skid register invalid; wait counter=0; timeout_o=0.
REQ-033 Reset during REQ/KILL abandons the request; a late mem_ready_i after reset is ignored in IDLE.

Structure
REQ-034 NOP_INST, the state encodings and the Enable/Disable/RstEnable levels live in the shared defines file.
REQ-035 One sub-module, fetch_skid, holds the skid data, its pc and valid bit; the FSM and IF/ID register stay in inst_fetch.

Verification
REQ-036 Zero-wait: pc_i=16'h0010, mem_ready_i high, data 16'h4901 -> inst_o=16'h4901, inst_pc_o=16'h0010, valid after 2 edges.
REQ-037 Wait 3: mem_ready_i low for 3 cycles -> fetch_pause_o high for exactly 3 cycles, mem_addr_o stable, then the instruction is delivered.
REQ-038 Pause at completion: pause_i=1 when ready arrives -> outputs hold; pause_i falls -> skid data appears next edge.
REQ-039 Flush in flight: flush_i in REQ before ready -> KILL, returned data dropped, inst_o=16'h0800, valid=0.
REQ-040 Conflict: mem_conflict_i=1 for 2 cycles in IDLE -> mem_req_o=0 and fetch_pause_o=1 for both cycles.
REQ-041 Timeout and reset: mem_ready_i held low for 8 cycles -> single timeout_o pulse; rst=0 mid-REQ -> all REQ-032 values next edge.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: NOP encoding, FSM state encoding, control levels.
// No logic of its own; imported by the fetch FSM and its skid register.
package inst_fetch_pkg;

    localparam logic [15:0] NOP_INST_DEF = 16'h0800;

    localparam logic ENABLE     = 1'b1;
    localparam logic DISABLE    = 1'b0;
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// Skid register: parks a completed fetch while decode is stalled.
// Latency: one cycle from load to valid_o; clear wins over load.
// Backpressure: none of its own, the fetch FSM decides when to load and drain.
module fetch_skid
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [15:0] data_i,
    input  logic [15:0] pc_i,
    output logic [15:0] data_o,
    output logic [15:0] pc_o,
    output logic        valid_o
);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            data_o  <= 16'h0000;
            pc_o    <= 16'h0000;
            valid_o <= DISABLE;
        end else if (clear) begin
            valid_o <= DISABLE;
        end else if (load) begin
            data_o  <= data_i;
            pc_o    <= pc_i;
            valid_o <= ENABLE;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: single-outstanding memory read feeding the IF/ID register.
// Latency: pc_i sampled on one edge, instruction registered on the next with zero-wait memory.
// Backpressure: pause_i holds IF/ID (completions skid); fetch_pause_o stalls the PC stage.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [15:0] NOP_INST = NOP_INST_DEF,
    parameter int          MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_i,
    input  logic        pause_i,
    input  logic        flush_i,
    input  logic        mem_conflict_i,
    input  logic        mem_ready_i,
    input  logic [15:0] mem_data_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] inst_o,
    output logic [15:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        fetch_pause_o,
    output logic        timeout_o
);

    localparam int            CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_SAT  = CW'(MAX_WAIT);

    fetch_state_t  state, state_nxt;
    logic [15:0]   req_pc;
    logic [CW-1:0] wait_cnt;
    logic [15:0]   fetch_addr;
    logic          fetch_req;
    logic          issue;
    logic          done;
    logic          unskid;
    logic          skid_load;
    logic          skid_clear;
    logic          waiting;
    logic [15:0]   skid_data;
    logic [15:0]   skid_pc;
    logic          skid_valid;

    always_comb begin
        state_nxt     = state;
        fetch_req     = DISABLE;
        fetch_addr    = 16'h0000;
        fetch_pause_o = DISABLE;
        issue         = DISABLE;
        done          = DISABLE;
        unskid        = DISABLE;
        skid_load     = DISABLE;
        case (state)
            S_IDLE: begin
                fetch_pause_o = mem_conflict_i;
                if (!mem_conflict_i && !pause_i) begin
                    fetch_req  = ENABLE;
                    fetch_addr = pc_i;
                    issue      = ENABLE;
                    state_nxt  = S_REQ;
                end
            end
            S_REQ: begin
                fetch_req     = ENABLE;
                fetch_addr    = req_pc;
                fetch_pause_o = !mem_ready_i;
                if (flush_i) begin
                    state_nxt = mem_ready_i ? S_IDLE : S_KILL;
                end else if (mem_ready_i) begin
                    if (pause_i) begin
                        skid_load = ENABLE;
                        state_nxt = S_HOLD;
                    end else begin
                        done      = ENABLE;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                fetch_pause_o = ENABLE;
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (!pause_i) begin
                    unskid    = skid_valid;
                    state_nxt = S_IDLE;
                end
            end
            S_KILL: begin
                // Memory still owes us a beat; keep the request up and throw the data away.
                fetch_req     = ENABLE;
                fetch_addr    = req_pc;
                fetch_pause_o = !mem_ready_i;
                if (mem_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A request is withdrawn immediately while reset is held.
    assign mem_req_o  = fetch_req & (rst != RST_ENABLE);
    assign mem_addr_o = mem_req_o ? fetch_addr : 16'h0000;

    assign waiting    = ((state == S_REQ) || (state == S_KILL)) && !mem_ready_i;
    assign skid_clear = flush_i | unskid;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state        <= S_IDLE;
            req_pc       <= 16'h0000;
            wait_cnt     <= '0;
            timeout_o    <= DISABLE;
            inst_o       <= NOP_INST;
            inst_pc_o    <= 16'h0000;
            inst_valid_o <= DISABLE;
        end else begin
            state <= state_nxt;

            if (issue) begin
                req_pc   <= pc_i;
                wait_cnt <= '0;
            end else if (waiting && (wait_cnt != WAIT_SAT)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            timeout_o <= waiting && (wait_cnt == WAIT_LAST);

            // Without a stall, a cycle with nothing delivered becomes a bubble.
            if (flush_i) begin
                inst_o       <= NOP_INST;
                inst_valid_o <= DISABLE;
            end else if (done) begin
                inst_o       <= mem_data_i;
                inst_pc_o    <= req_pc;
                inst_valid_o <= ENABLE;
            end else if (unskid) begin
                inst_o       <= skid_data;
                inst_pc_o    <= skid_pc;
                inst_valid_o <= ENABLE;
            end else if (!pause_i) begin
                inst_o       <= NOP_INST;
                inst_valid_o <= DISABLE;
            end
        end
    end

    fetch_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .data_i  (mem_data_i),
        .pc_i    (req_pc),
        .data_o  (skid_data),
        .pc_o    (skid_pc),
        .valid_o (skid_valid)
    );

endmodule
